instr_fetch_unit: RTL and testbench

Instruction sequencer that sits directly upstream of the datapath/control unit (arquitectura). It holds a small loadable program memory and a program counter. It issues one 8-bit instruction at a time to the datapath's instruction input over a valid/ready handshake. It stops on a HALT word or at the end of memory, so benches and the top level stop driving instruction words by hand.

---
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction sequencer: a loadable program memory and a PC that issue one word
// at a time over valid/ready, stopping on HALT_WORD or at the last address.
module instr_fetch_unit #(
    parameter int              IW        = 8,
    parameter int              DEPTH     = 16,
    parameter int              AW        = 4,
    parameter logic [IW-1:0]   HALT_WORD = 8'hFF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic          start,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic          running,
    output logic          halted
);

    // state   | meaning
    // S_IDLE  | out of reset, waiting for start; memory writable
    // S_FETCH | one cycle: read mem[pc], either issue it or stop on HALT_WORD
    // S_ISSUE | instr_valid high, waiting for instr_ready
    // S_HALT  | stopped on HALT_WORD or end of memory; writable, start restarts
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_t;

    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [IW-1:0] r_instr;
    logic          r_valid;
    logic          r_running;
    logic          r_halted;
    logic [IW-1:0] r_mem [DEPTH];

    logic          w_prog_ok;
    logic [IW-1:0] w_fetch_word;

    // Writes are only accepted while nothing is being sequenced.
    assign w_prog_ok    = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_fetch_word = r_mem[r_pc];

    always_ff @(posedge clk) begin
        if (prog_we && w_prog_ok) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_instr   <= '0;
            r_valid   <= 1'b0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_pc      <= '0;
                        r_running <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (w_fetch_word == HALT_WORD) begin
                        r_state   <= S_HALT;
                        r_halted  <= 1'b1;
                        r_running <= 1'b0;
                    end else begin
                        r_instr <= w_fetch_word;
                        r_valid <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        r_valid <= 1'b0;
                        // No wrap: the last address ends the program.
                        if (r_pc == LAST_PC) begin
                            r_state   <= S_HALT;
                            r_halted  <= 1'b1;
                            r_running <= 1'b0;
                        end else begin
                            r_pc    <= r_pc + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_pc      <= '0;
                        r_halted  <= 1'b0;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign running     = r_running;
    assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized programs checked
// against a program-walk model of what should be issued.
module tb_instr_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       start;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] pc;
    logic       running;
    logic       halted;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc         (pc),
        .running    (running),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_mem [16];
    logic [7:0] exp_instr [$];
    logic [3:0] exp_pc [$];
    int         exp_final_pc;

    logic [7:0] cap_instr [$];
    logic [3:0] cap_pc [$];
    int         cap_cyc [$];
    bit         cap_timeout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
        m_mem[a]  = d;
    endtask

    // Model: walk memory from 0, issuing every word until FF or the end.
    task automatic build_expected();
        exp_instr.delete();
        exp_pc.delete();
        exp_final_pc = 15;
        for (int a = 0; a < 16; a++) begin
            if (m_mem[a] == 8'hFF) begin
                exp_final_pc = a;
                break;
            end
            exp_instr.push_back(m_mem[a]);
            exp_pc.push_back(4'(a));
        end
    endtask

    // Pulses start then records every handshake until halted or budget runs out.
    task automatic run_capture(input int ready_pct, input bit poke, input int budget);
        int cyc;
        cap_instr.delete();
        cap_pc.delete();
        cap_cyc.delete();
        cap_timeout = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        prog_we = 1'b0;
        cyc = 0;
        while (!halted && cyc < budget) begin
            instr_ready = (int'($urandom_range(99)) < ready_pct);
            if (poke && running && $urandom_range(3) == 0) begin
                prog_we   = 1'b1;
                prog_addr = 4'($urandom);
                prog_data = 8'($urandom);
            end else begin
                prog_we = 1'b0;
            end
            if (instr_valid && instr_ready) begin
                cap_instr.push_back(instr);
                cap_pc.push_back(pc);
                cap_cyc.push_back(cyc);
            end
            tick();
            cyc++;
        end
        prog_we     = 1'b0;
        instr_ready = 1'b0;
        if (!halted) cap_timeout = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_halted(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (halted) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; prog_we = 1'b0; instr_ready = 1'b0;
        prog_addr = '0; prog_data = '0;
        tick();
        tick();
        checks++; if (instr !== 8'h00) begin failures++; $display("FAIL rst_instr got=%h exp=00", instr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        checks++; if (pc !== 4'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", pc); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL rst_running got=%b exp=0", running); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", halted); end
        rst_n = 1'b1; start = 1'b0;
        tick();
    endtask

    task automatic test_program_run();
        for (int a = 0; a < 16; a++) m_mem[a] = 8'h00;
        load_word(4'd0, 8'h01);
        load_word(4'd1, 8'h81);
        load_word(4'd2, 8'hB2);
        load_word(4'd3, 8'hFF);
        build_expected();
        run_capture(100, 1'b0, 60);
        checks++; if (cap_timeout) begin failures++; $display("FAIL run_timeout got=not_halted exp=halted"); end
        checks++; if (cap_instr.size() != exp_instr.size()) begin failures++; $display("FAIL run_count got=%0d exp=%0d", cap_instr.size(), exp_instr.size()); end
        for (int i = 0; i < cap_instr.size() && i < exp_instr.size(); i++) begin
            checks++; if (cap_instr[i] !== exp_instr[i]) begin failures++; $display("FAIL run_instr[%0d] got=%h exp=%h", i, cap_instr[i], exp_instr[i]); end
            // First valid one edge after the start edge, then one every 2 cycles.
            checks++; if (cap_cyc[i] != 1 + 2 * i) begin failures++; $display("FAIL run_timing[%0d] got=%0d exp=%0d", i, cap_cyc[i], 1 + 2 * i); end
        end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL run_halted got=%b exp=1", halted); end
        checks++; if (pc !== 4'd3) begin failures++; $display("FAIL run_pc got=%h exp=3", pc); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL run_running got=%b exp=0", running); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL run_valid_after got=%b exp=0", instr_valid); end
    endtask

    task automatic test_backpressure();
        bit ok;
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(10, ok);
        checks++; if (!ok || instr !== 8'h01) begin failures++; $display("FAIL bp_first got=%h ok=%b exp=01", instr, ok); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        wait_valid(10, ok);
        checks++; if (!ok || instr !== 8'h81 || pc !== 4'd1) begin failures++; $display("FAIL bp_second got=%h pc=%h exp=81 pc=1", instr, pc); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (instr !== 8'h81 || instr_valid !== 1'b1 || pc !== 4'd1) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=%h v=%b pc=%h exp=81 v=1 pc=1", i, instr, instr_valid, pc);
            end
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        wait_valid(10, ok);
        checks++; if (!ok || instr !== 8'hB2 || pc !== 4'd2) begin failures++; $display("FAIL bp_third got=%h pc=%h exp=B2 pc=2", instr, pc); end
        instr_ready = 1'b1;
        wait_halted(10, ok);
        instr_ready = 1'b0;
        checks++; if (!ok || pc !== 4'd3) begin failures++; $display("FAIL bp_halt got=%b pc=%h exp=1 pc=3", halted, pc); end
    endtask

    task automatic test_end_of_memory();
        bit seen_valid;
        for (int a = 0; a < 16; a++) load_word(4'(a), 8'h00);
        build_expected();
        run_capture(100, 1'b0, 100);
        checks++; if (cap_timeout) begin failures++; $display("FAIL eom_timeout got=not_halted exp=halted"); end
        checks++; if (cap_instr.size() != 16) begin failures++; $display("FAIL eom_count got=%0d exp=16", cap_instr.size()); end
        for (int i = 0; i < cap_pc.size() && i < exp_pc.size(); i++) begin
            checks++;
            if (cap_pc[i] !== exp_pc[i] || cap_instr[i] !== 8'h00) begin
                failures++;
                $display("FAIL eom_issue[%0d] got=%h/%h exp=%h/00", i, cap_pc[i], cap_instr[i], exp_pc[i]);
            end
        end
        checks++; if (halted !== 1'b1 || pc !== 4'd15) begin failures++; $display("FAIL eom_halt got=%b pc=%h exp=1 pc=f", halted, pc); end
        seen_valid = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (instr_valid) seen_valid = 1'b1;
            tick();
        end
        instr_ready = 1'b0;
        checks++; if (seen_valid) begin failures++; $display("FAIL eom_no_17th got=valid exp=no_valid"); end
    endtask

    task automatic test_write_during_run();
        bit ok;
        for (int a = 0; a < 16; a++) load_word(4'(a), 8'h00);
        load_word(4'd0, 8'h01);
        load_word(4'd1, 8'h81);
        load_word(4'd2, 8'hB2);
        load_word(4'd3, 8'hFF);
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(10, ok);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        wait_valid(10, ok);
        checks++; if (!ok || pc !== 4'd1) begin failures++; $display("FAIL wdr_at_pc1 got=%h exp=1", pc); end
        prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'hAA;
        tick();
        prog_we = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        wait_valid(10, ok);
        checks++; if (!ok || instr !== 8'hB2) begin failures++; $display("FAIL wdr_ignored got=%h exp=B2", instr); end
        instr_ready = 1'b1;
        wait_halted(10, ok);
        instr_ready = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL wdr_halt got=%b exp=1", halted); end
        load_word(4'd2, 8'hAA);
        // Write to address 0 on the same edge as start must reach the first fetch.
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h37;
        m_mem[0] = 8'h37;
        build_expected();
        run_capture(100, 1'b0, 60);
        checks++; if (cap_instr.size() != 3) begin failures++; $display("FAIL wdr_count got=%0d exp=3", cap_instr.size()); end
        for (int i = 0; i < cap_instr.size() && i < exp_instr.size(); i++) begin
            checks++; if (cap_instr[i] !== exp_instr[i]) begin failures++; $display("FAIL wdr_instr[%0d] got=%h exp=%h", i, cap_instr[i], exp_instr[i]); end
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rmr_valid_before got=%b exp=1", instr_valid); end
        rst_n = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || pc !== 4'd0 || running !== 1'b0 || halted !== 1'b0 || instr !== 8'h00) begin
            failures++;
            $display("FAIL rmr_after got=v%b pc%h r%b h%b i%h exp=v0 pc0 r0 h0 i00", instr_valid, pc, running, halted, instr);
        end
        rst_n = 1'b1;
        tick();
        build_expected();
        run_capture(100, 1'b0, 60);
        checks++; if (cap_instr.size() != exp_instr.size()) begin failures++; $display("FAIL rmr_count got=%0d exp=%0d", cap_instr.size(), exp_instr.size()); end
        for (int i = 0; i < cap_instr.size() && i < exp_instr.size(); i++) begin
            checks++; if (cap_instr[i] !== exp_instr[i] || cap_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL rmr_instr[%0d] got=%h exp=%h", i, cap_instr[i], exp_instr[i]); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 16; a++) begin
                if ($urandom_range(9) == 0) load_word(4'(a), 8'hFF);
                else load_word(4'(a), 8'($urandom_range(254)));
            end
            build_expected();
            run_capture(30 + 10 * it, 1'b1, 400);
            checks++; if (cap_timeout) begin failures++; $display("FAIL rnd%0d_timeout got=not_halted exp=halted", it); end
            checks++; if (cap_instr.size() != exp_instr.size()) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, cap_instr.size(), exp_instr.size()); end
            for (int i = 0; i < cap_instr.size() && i < exp_instr.size(); i++) begin
                checks++;
                if (cap_instr[i] !== exp_instr[i] || cap_pc[i] !== exp_pc[i]) begin
                    failures++;
                    $display("FAIL rnd%0d_issue[%0d] got=%h@%h exp=%h@%h", it, i, cap_instr[i], cap_pc[i], exp_instr[i], exp_pc[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (cap_cyc[i] - cap_cyc[i-1] < 2) begin failures++; $display("FAIL rnd%0d_gap[%0d] got=%0d exp>=2", it, i, cap_cyc[i] - cap_cyc[i-1]); end
                end
            end
            checks++; if (halted !== 1'b1 || int'(pc) != exp_final_pc) begin failures++; $display("FAIL rnd%0d_final got=h%b pc%0d exp=h1 pc%0d", it, halted, pc, exp_final_pc); end
        end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) m_mem[a] = 8'h00;
        test_reset();
        test_program_run();
        test_backpressure();
        test_end_of_memory();
        test_write_during_run();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
